// File: rtl/mvb_rx_frame_ctrl.sv
// MVB receive frame controller: sequences start/delimiter, data words, check sequences
// and end delimiter of one frame. Optional watchdog when MVB_RX_TIMEOUT_EN is defined.
module mvb_rx_frame_ctrl #(
  parameter int unsigned WORDS_PER_CRC = 4,
  parameter int unsigned MAX_WORDS     = 16,
  parameter int unsigned BITS_PER_WORD = 16,
  parameter int unsigned CRC_BITS      = 8,
  parameter int unsigned DELIM_BITS    = 9,
  parameter int unsigned END_BITS      = 3,
  parameter int unsigned TIMEOUT_CYC   = 64
) (
  input  logic       clk_24M,
  input  logic       rst,
  input  logic       bit_tick,
  input  logic       frame_start,
  input  logic       s_delim,
  input  logic       m_delim,
  input  logic       e_delim,
  input  logic       delim_error,
  input  logic       signal_error,
  input  logic       crc_error,
  input  logic [5:0] frame_words,
  output logic       start_check_en,
  output logic       delimiter_check_en,
  output logic       deserializer_en,
  output logic       deserializer_wait,
  output logic       crc_check_en,
  output logic       crc_read,
  output logic       frame_end,
  output logic       frame_over,
  output logic       frame_ok,
  output logic [2:0] err_code,
  output logic [5:0] word_count
);

  typedef enum logic [2:0] {IDLE, DELIM, DATA, CRC, EDEL, DONE, ERR} state_e;
  typedef enum logic [2:0] {
    E_NONE = 3'd0, E_DELIM = 3'd1, E_LEN = 3'd2, E_SIG = 3'd3,
    E_CRC = 3'd4, E_END = 3'd5, E_TIMEOUT = 3'd6
  } err_e;

  localparam int unsigned MAX_A    = (DELIM_BITS > BITS_PER_WORD) ? DELIM_BITS : BITS_PER_WORD;
  localparam int unsigned MAX_B    = (CRC_BITS > END_BITS) ? CRC_BITS : END_BITS;
  localparam int unsigned MAX_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);
  localparam int unsigned BLK_W    = $clog2(WORDS_PER_CRC + 1);

  localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_BITS - 1);
  localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(BITS_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_BITS - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_BITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(WORDS_PER_CRC - 1);
  localparam logic [5:0]       MAX_LEN    = 6'(MAX_WORDS);

  state_e           state_q, state_d;
  err_e             err_q, err_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [5:0]       word_cnt_q, word_cnt_d;
  logic [5:0]       len_q, len_d;
  logic             crc_read_d;
  logic             active;

  logic start_check_en_q, delimiter_check_en_q, deserializer_en_q, deserializer_wait_q;
  logic crc_check_en_q, crc_read_q, frame_end_q, frame_over_q, frame_ok_q;

`ifdef MVB_RX_TIMEOUT_EN
  localparam int unsigned      WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  assign active = (state_q == DELIM) || (state_q == DATA) ||
                  (state_q == CRC)   || (state_q == EDEL);

  always_comb begin
    // NOTE: every _d variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    err_d      = err_q;
    bit_cnt_d  = bit_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    crc_read_d = 1'b0;
`ifdef MVB_RX_TIMEOUT_EN
    wd_d = (bit_tick || !active) ? '0 : wd_q + 1'b1;
`endif

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = DELIM;
          err_d      = E_NONE;
          word_cnt_d = '0;
          blk_cnt_d  = '0;
        end
      end
      DELIM: begin
        if (bit_tick) begin
          if (bit_cnt_q == DELIM_LAST) begin
            if (m_delim && !delim_error) begin
              len_d   = 6'd1;
              state_d = DATA;
            end else if (s_delim && !delim_error) begin
              len_d = frame_words;
              if (frame_words == '0 || frame_words > MAX_LEN) begin
                state_d = ERR;
                err_d   = E_LEN;
              end else begin
                state_d = DATA;
              end
            end else begin
              state_d = ERR;
              err_d   = E_DELIM;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == WORD_LAST) begin
            bit_cnt_d = '0;
            if (word_cnt_q < MAX_LEN) word_cnt_d = word_cnt_q + 1'b1;
            // A check sequence follows every full block and the final (possibly short) block.
            if (blk_cnt_q == BLK_LAST || word_cnt_d == len_q) begin
              state_d   = CRC;
              blk_cnt_d = '0;
            end else begin
              blk_cnt_d = blk_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      CRC: begin
        if (bit_tick) begin
          if (bit_cnt_q == CRC_LAST) begin
            crc_read_d = 1'b1;
            if (crc_error) begin
              state_d = ERR;
              err_d   = E_CRC;
            end else if (word_cnt_q == len_q) begin
              state_d = EDEL;
            end else begin
              state_d = DATA;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      EDEL: begin
        if (bit_tick) begin
          if (bit_cnt_q == END_LAST) begin
            if (e_delim && !delim_error) begin
              state_d = DONE;
            end else begin
              state_d = ERR;
              err_d   = E_END;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MVB_RX_TIMEOUT_EN
    if (active && !bit_tick && wd_q == WD_LAST) begin
      state_d = ERR;
      err_d   = E_TIMEOUT;
    end
`endif
    // A line fault outranks every other abort cause.
    if (active && signal_error) begin
      state_d = ERR;
      err_d   = E_SIG;
    end
    if (state_d != state_q) bit_cnt_d = '0;
  end

  always_ff @(posedge clk_24M) begin
    if (rst) begin
      state_q              <= IDLE;
      err_q                <= E_NONE;
      bit_cnt_q            <= '0;
      blk_cnt_q            <= '0;
      word_cnt_q           <= '0;
      len_q                <= '0;
      start_check_en_q     <= 1'b1;
      delimiter_check_en_q <= 1'b0;
      deserializer_en_q    <= 1'b0;
      deserializer_wait_q  <= 1'b0;
      crc_check_en_q       <= 1'b0;
      crc_read_q           <= 1'b0;
      frame_end_q          <= 1'b0;
      frame_over_q         <= 1'b0;
      frame_ok_q           <= 1'b0;
`ifdef MVB_RX_TIMEOUT_EN
      wd_q                 <= '0;
`endif
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      bit_cnt_q  <= bit_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      // NOTE: outputs decode state_d so they are flops yet line up with state_q.
      start_check_en_q     <= (state_d == IDLE);
      delimiter_check_en_q <= (state_d == DELIM) || (state_d == EDEL);
      deserializer_en_q    <= (state_d == DATA);
      deserializer_wait_q  <= (state_d == CRC);
      crc_check_en_q       <= (state_d == DATA);
      crc_read_q           <= crc_read_d;
      frame_end_q          <= (state_d == EDEL);
      frame_over_q         <= (state_d == DONE) || (state_d == ERR);
      frame_ok_q           <= (state_d == DONE);
`ifdef MVB_RX_TIMEOUT_EN
      wd_q                 <= wd_d;
`endif
    end
  end

  assign start_check_en     = start_check_en_q;
  assign delimiter_check_en = delimiter_check_en_q;
  assign deserializer_en    = deserializer_en_q;
  assign deserializer_wait  = deserializer_wait_q;
  assign crc_check_en       = crc_check_en_q;
  assign crc_read           = crc_read_q;
  assign frame_end          = frame_end_q;
  assign frame_over         = frame_over_q;
  assign frame_ok           = frame_ok_q;
  assign err_code           = err_q;
  assign word_count         = word_cnt_q;

endmodule

// File: tb/tb_mvb_rx_frame_ctrl.sv
// Self-checking bench for mvb_rx_frame_ctrl: table of frames with a completion
// scoreboard, plus directed reset, signal-error and watchdog sequences.
module tb_mvb_rx_frame_ctrl;

  logic       clk_24M = 1'b0;
  logic       rst = 1'b1;
  logic       bit_tick = 1'b0, frame_start = 1'b0;
  logic       s_delim = 1'b0, m_delim = 1'b0, e_delim = 1'b0;
  logic       delim_error = 1'b0, signal_error = 1'b0, crc_error = 1'b0;
  logic [5:0] frame_words = '0;
  logic       start_check_en, delimiter_check_en, deserializer_en, deserializer_wait;
  logic       crc_check_en, crc_read, frame_end, frame_over, frame_ok;
  logic [2:0] err_code;
  logic [5:0] word_count;

  mvb_rx_frame_ctrl dut (
    .clk_24M(clk_24M), .rst(rst), .bit_tick(bit_tick), .frame_start(frame_start),
    .s_delim(s_delim), .m_delim(m_delim), .e_delim(e_delim), .delim_error(delim_error),
    .signal_error(signal_error), .crc_error(crc_error), .frame_words(frame_words),
    .start_check_en(start_check_en), .delimiter_check_en(delimiter_check_en),
    .deserializer_en(deserializer_en), .deserializer_wait(deserializer_wait),
    .crc_check_en(crc_check_en), .crc_read(crc_read), .frame_end(frame_end),
    .frame_over(frame_over), .frame_ok(frame_ok), .err_code(err_code),
    .word_count(word_count)
  );

  initial forever #20 clk_24M = ~clk_24M;

  typedef enum logic [1:0] {K_MASTER, K_SLAVE, K_BAD} kind_e;
  typedef struct {
    kind_e      kind;
    logic [5:0] words;
    int         crc_fail;   // index of the failing check, 0 = none
    logic       sig;        // signal_error together with the failing check
    logic       e_ok;
    logic       late;       // extra frame_start during DONE/ERR
    logic       exp_ok;
    logic [2:0] exp_err;
    logic [5:0] exp_wc;
    int         exp_reads;
    int         exp_waits;
    int         exp_ends;
  } vec_t;
  typedef struct {
    logic       ok;
    logic [2:0] err;
    logic [5:0] wc;
    int         reads;
    int         waits;
    int         ends;
  } exp_t;

  localparam int NV = 12;
  localparam logic [17:0] RST_OUTS = 18'h20000;

  vec_t  vecs[NV];
  exp_t  sb_q[$];
  exp_t  mon_e;
  int    checks = 0, failures = 0;
  int    reads_seen = 0, waits_seen = 0, ends_seen = 0, fo_cnt = 0;
  string cur_name = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] outs();
    return {start_check_en, delimiter_check_en, deserializer_en, deserializer_wait,
            crc_check_en, crc_read, frame_end, frame_over, frame_ok, err_code, word_count};
  endfunction

  // Completion monitor: pops one expectation per frame_over pulse.
  initial forever begin
    @(negedge clk_24M);
    if (rst) begin
      reads_seen = 0; waits_seen = 0; ends_seen = 0;
    end else begin
      if (crc_read) reads_seen++;
      if (deserializer_wait && bit_tick) waits_seen++;
      if (frame_end && bit_tick) ends_seen++;
      if (frame_over) begin
        fo_cnt++;
        if (sb_q.size() == 0) begin
          check({cur_name, "_unexpected_frame_over"}, 32'(frame_over), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check({cur_name, "_frame_ok"},   32'(frame_ok),   32'(mon_e.ok));
          check({cur_name, "_err_code"},   32'(err_code),   32'(mon_e.err));
          check({cur_name, "_word_count"}, 32'(word_count), 32'(mon_e.wc));
          check({cur_name, "_crc_reads"},  reads_seen,      mon_e.reads);
          check({cur_name, "_wait_ticks"}, waits_seen,      mon_e.waits);
          check({cur_name, "_end_ticks"},  ends_seen,       mon_e.ends);
        end
        reads_seen = 0; waits_seen = 0; ends_seen = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1);
  end

  task automatic tick(input logic late_start);
    bit_tick = 1'b1;
    @(posedge clk_24M); #1;
    bit_tick    = 1'b0;
    frame_start = late_start;
    @(posedge clk_24M); #1;
    frame_start = 1'b0;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk_24M); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_sb_empty(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk_24M); n++;
    end
    #1;
    check({cur_name, "_completed"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic drive_frame(input vec_t v);
    logic [5:0] len;
    logic       stop_delim;
    logic       fail;
    int         chk;
    len        = (v.kind == K_MASTER) ? 6'd1 : v.words;
    stop_delim = (v.kind == K_BAD) || (len == 6'd0) || (len > 6'd16);
    frame_words = v.words;
    start_frame();
    for (int b = 0; b < 9; b++) begin
      m_delim = (b == 8) && (v.kind == K_MASTER);
      s_delim = (b == 8) && (v.kind == K_SLAVE);
      tick((b == 8) && stop_delim && v.late);
    end
    m_delim = 1'b0; s_delim = 1'b0;
    if (stop_delim) return;
    chk = 0;
    for (int w = 1; w <= int'(len); w++) begin
      repeat (16) tick(1'b0);
      if (w % 4 == 0 || w == int'(len)) begin
        chk++;
        for (int c = 0; c < 8; c++) begin
          fail         = (c == 7) && (chk == v.crc_fail);
          crc_error    = fail;
          signal_error = fail && v.sig;
          tick(fail && v.late);
        end
        crc_error = 1'b0; signal_error = 1'b0;
        if (chk == v.crc_fail) return;
      end
    end
    for (int e = 0; e < 3; e++) begin
      e_delim = (e == 2) && v.e_ok;
      tick((e == 2) && v.late);
    end
    e_delim = 1'b0;
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    cur_name = $sformatf("vec%0d", idx);
    sb_q.push_back('{v.exp_ok, v.exp_err, v.exp_wc, v.exp_reads, v.exp_waits, v.exp_ends});
    drive_frame(v);
    wait_sb_empty(40);
    if (v.late) begin
      @(negedge clk_24M);
      check({cur_name, "_late_start_ignored"}, 32'({start_check_en, delimiter_check_en}), 32'd2);
      check({cur_name, "_err_code_held"}, 32'(err_code), 32'(v.exp_err));
    end
    repeat (2) @(posedge clk_24M);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk_24M); #1;
    rst = 1'b0;
    @(posedge clk_24M); #1;
  endtask

  int fo_before;

  initial begin
    //            kind      words  fail sig   e_ok  late  ok    err   wc     rd wt end
    vecs[0]  = '{K_MASTER, 6'd0,  0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 6'd1,  1, 8,  3};
    vecs[1]  = '{K_SLAVE,  6'd8,  0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 6'd8,  2, 16, 3};
    vecs[2]  = '{K_SLAVE,  6'd0,  0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 6'd0,  0, 0,  0};
    vecs[3]  = '{K_SLAVE,  6'd17, 0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 6'd0,  0, 0,  0};
    vecs[4]  = '{K_SLAVE,  6'd8,  2, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 6'd8,  2, 16, 0};
    vecs[5]  = '{K_MASTER, 6'd0,  0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 6'd1,  1, 8,  3};
    vecs[6]  = '{K_BAD,    6'd4,  0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 6'd0,  0, 0,  0};
    vecs[7]  = '{K_SLAVE,  6'd5,  0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 6'd5,  2, 16, 3};
    vecs[8]  = '{K_SLAVE,  6'd16, 0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 6'd16, 4, 32, 3};
    vecs[9]  = '{K_SLAVE,  6'd1,  0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 6'd1,  1, 8,  3};
    vecs[10] = '{K_SLAVE,  6'd3,  1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 6'd3,  1, 8,  0};
    vecs[11] = '{K_SLAVE,  6'd4,  1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 6'd4,  1, 8,  0};

    cur_name = "reset";
    repeat (3) @(posedge clk_24M);
    @(negedge clk_24M);
    check("reset_outputs", 32'(outs()), 32'(RST_OUTS));
    @(posedge clk_24M); #1;
    rst = 1'b0;
    @(negedge clk_24M);
    check("idle_after_reset", 32'(outs()), 32'(RST_OUTS));
    @(posedge clk_24M); #1;

    for (int i = 0; i < NV; i++) run_frame(i, vecs[i]);

    // signal_error mid-word, no bit_tick in that cycle
    cur_name = "signal_mid_data";
    sb_q.push_back('{1'b0, 3'd3, 6'd0, 0, 0, 0});
    frame_words = 6'd0;
    start_frame();
    for (int b = 0; b < 9; b++) begin
      m_delim = (b == 8);
      tick(1'b0);
    end
    m_delim = 1'b0;
    repeat (3) tick(1'b0);
    signal_error = 1'b1;
    @(posedge clk_24M); #1;
    signal_error = 1'b0;
    wait_sb_empty(10);
    repeat (2) @(posedge clk_24M);
    #1;

    // reset while a check sequence is in progress
    cur_name = "reset_in_crc";
    frame_words = 6'd8;
    start_frame();
    @(negedge clk_24M);
    check("delim_phase_enables", 32'({start_check_en, delimiter_check_en}), 32'd1);
    @(posedge clk_24M); #1;
    for (int b = 0; b < 9; b++) begin
      s_delim = (b == 8);
      tick(1'b0);
    end
    s_delim = 1'b0;
    @(negedge clk_24M);
    check("data_phase_enables",
          32'({deserializer_en, crc_check_en, delimiter_check_en, deserializer_wait}), 32'hC);
    @(posedge clk_24M); #1;
    repeat (4 * 16) tick(1'b0);
    @(negedge clk_24M);
    check("crc_phase_state", 32'({deserializer_wait, deserializer_en, word_count}), 32'h84);
    @(posedge clk_24M); #1;
    repeat (3) tick(1'b0);
    fo_before = fo_cnt;
    rst = 1'b1;
    @(posedge clk_24M);
    @(negedge clk_24M);
    check("reset_in_crc_outputs", 32'(outs()), 32'(RST_OUTS));
    rst = 1'b0;
    repeat (12) @(posedge clk_24M);
    @(negedge clk_24M);
    check("reset_in_crc_no_frame_over", fo_cnt, fo_before);
    check("reset_in_crc_idle", 32'(outs()), 32'(RST_OUTS));
    @(posedge clk_24M); #1;

    // bit_tick stops in DATA
    cur_name = "tick_stall";
    fo_before = fo_cnt;
`ifdef MVB_RX_TIMEOUT_EN
    sb_q.push_back('{1'b0, 3'd6, 6'd0, 0, 0, 0});
`endif
    start_frame();
    for (int b = 0; b < 9; b++) begin
      m_delim = (b == 8);
      tick(1'b0);
    end
    m_delim = 1'b0;
    repeat (5) tick(1'b0);
    repeat (50) @(posedge clk_24M);
    @(negedge clk_24M);
    check("stall_no_early_abort", 32'(deserializer_en), 32'd1);
    @(posedge clk_24M); #1;
`ifdef MVB_RX_TIMEOUT_EN
    wait_sb_empty(40);
    check("stall_timeout_code", 32'(err_code), 32'd6);
`else
    repeat (60) @(posedge clk_24M);
    @(negedge clk_24M);
    check("stall_stays_in_data", 32'({deserializer_en, frame_over}), 32'd2);
    check("stall_no_frame_over", fo_cnt, fo_before);
    @(posedge clk_24M); #1;
`endif
    pulse_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvb_rx_frame_ctrl.md
MVB_RX_FRAME_CTRL -- requirements
Module: mvb_rx_frame_ctrl

Interface
REQ-001 SHALL have parameters: WORDS_PER_CRC, default 4, data words covered by one check sequence; MAX_WORDS, default 16, largest slave frame in 16-bit words; BITS_PER_WORD, default 16; CRC_BITS, default 8; DELIM_BITS, default 9, start delimiter length in bit times; END_BITS, default 3, end delimiter length in bit times; TIMEOUT_CYC, default 64, clocks without bit_tick before abort.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_24M, in, 1, sole clock; one clock; reset is synchronous and active-high.
- rst, in, 1, synchronous active-high reset.
- bit_tick, in, 1, one-cycle strobe per received bit time.
- frame_start, in, 1, start bit detected.
- s_delim / m_delim / e_delim, in, 1 each, slave, master or end delimiter recognised.
- delim_error, signal_error, crc_error, in, 1 each, error flags from the datapath.
- frame_words, in, 6, slave frame length in words.
- start_check_en, delimiter_check_en, deserializer_en, deserializer_wait, crc_check_en, out, 1 each, datapath enables.
- crc_read, out, 1, one-cycle pulse that latches the check result.
- frame_end, out, 1, high during the end delimiter.
- frame_over, out, 1, one-cycle completion pulse.
- frame_ok, out, 1, qualifies frame_over.
- err_code, out, 3, abort cause.
- word_count, out, 6, words received.

Function
REQ-003 SHALL implement the states IDLE, DELIM, DATA, CRC, EDEL, DONE and ERR; all outputs SHALL be registered.
REQ-004 IDLE: start_check_en=1; when frame_start=1 the block SHALL move to DELIM on the next clock. frame_start SHALL be ignored in every other state.
REQ-005 DELIM: delimiter_check_en=1; the block SHALL count DELIM_BITS bit_ticks. On the last tick:
- m_delim=1: frame length is latched as 1, go to DATA.
- s_delim=1: frame_words is latched, go to DATA; if frame_words is 0 or greater than MAX_WORDS, go to ERR with code 2.
- otherwise: go to ERR with code 1.
REQ-006 DATA: deserializer_en=1 and crc_check_en=1. Every BITS_PER_WORD ticks, word_count SHALL increment. Entry to CRC SHALL occur on the tick that makes word_count a multiple of WORDS_PER_CRC, or equal to the latched length.
REQ-007 CRC: deserializer_wait=1 for CRC_BITS ticks. On the last tick, crc_read SHALL pulse for one clock and crc_error SHALL be sampled in the same cycle.
- crc_error=1: go to ERR with code 4.
- word_count equals the latched length: go to EDEL.
- otherwise: go to DATA.
REQ-008 EDEL: frame_end=1 and delimiter_check_en=1 for END_BITS ticks. On the last tick, e_delim=1 goes to DONE; otherwise go to ERR with code 5.
REQ-009 DONE: frame_over=1 and frame_ok=1 for one clock, then go to IDLE.
REQ-010 ERR: frame_over=1, frame_ok=0 and err_code held for one clock, then go to IDLE; err_code SHALL hold its value until the next frame_start.
REQ-011 signal_error=1 in DELIM, DATA, CRC or EDEL SHALL force ERR with code 3 on the next clock. If several causes occur in the same cycle, priority SHALL be signal (3), then crc (4), then the state-specific cause.
REQ-012 The bit counter SHALL clear on every state change; counts SHALL wrap only through these state changes, and word_count SHALL never exceed MAX_WORDS.
REQ-013 err_code encoding: 0 none, 1 delimiter, 2 length, 3 signal, 4 crc, 5 end delimiter, 6 timeout.

Reset
REQ-014 With rst=1 at a clock edge: state goes to IDLE; all counters clear; start_check_en=1; every other output is 0, including err_code=0.
REQ-015 Reset mid-frame SHALL abort the frame without a frame_over pulse.

Configuration
REQ-016 Macro MVB_RX_TIMEOUT_EN:
- Defined: a watchdog counts clocks since the last bit_tick in any state other than IDLE, DONE or ERR; reaching TIMEOUT_CYC forces ERR with code 6.
- Undefined: no watchdog logic exists and code 6 is never produced.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Master frame: frame_start, m_delim at tick 9, 16 data ticks, 8 crc ticks, e_delim at tick 3 -> word_count=1, one crc_read pulse, frame_over=1, frame_ok=1, err_code=0.
- Slave frame with frame_words=8: -> CRC entered at words 4 and 8, two crc_read pulses, deserializer_wait high for 16 ticks in total, frame_ok=1.
- Slave frame with frame_words=0, then frame_words=17 -> ERR with err_code=2, frame_over pulse, frame_ok=0.
- crc_error=1 at the second check of an 8-word frame -> err_code=4 and return to IDLE; a second frame_start issued during DONE or ERR is ignored.
- With MVB_RX_TIMEOUT_EN defined, bit_tick stopped in DATA for 64 clocks -> err_code=6; with the macro undefined, the block stays in DATA.
- rst asserted during CRC -> outputs take their reset values next cycle and no frame_over pulse is produced.
